// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding RV32 instruction fetch sequencer with redirects and fault delivery
// Ports: clk, reset (async, active-high); halt; redirect_valid/redirect_target from execute;
//        imem_req_valid/ready/addr request handshake; imem_rsp_valid/data/err response;
//        inst_valid/ready/data/pc/fault handshake to decode; pc = next address to request.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_fault,
  output logic [31:0] pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state_q, state_d, go;
  logic [31:0] pc_q, pc_d, pc_n, req_addr_q, req_addr_d, req_pc_q, req_pc_d;
  logic [31:0] data_q, data_d, ipc_q, ipc_d;
  logic [1:0] fault_q, fault_d;
  logic drop_q, drop_d, mis_q, mis_d, mis_n, term_q, term_d, stale;
  always_comb begin
    mis_n = redirect_valid ? |redirect_target[1:0] : mis_q;
    pc_n = redirect_valid ? redirect_target : pc_q;
    // where a free fetch slot goes: a pending misaligned target becomes a NOP fault instead of a request
    go = mis_n ? HOLD : (halt ? IDLE : REQ);
    stale = drop_q | redirect_valid;
    state_d = state_q;
    pc_d = pc_n;
    drop_d = drop_q;
    mis_d = mis_n;
    term_d = term_q & ~redirect_valid;
    req_pc_d = req_pc_q;
    data_d = data_q;
    ipc_d = ipc_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: state_d = (mis_n || (!halt && !term_d)) ? go : IDLE;
      REQ: begin
        // a redirect while the request is pending cannot withdraw it; its response is dropped instead
        drop_d = stale;
        if (imem_req_ready) begin
          state_d = WAIT;
          req_pc_d = req_addr_q;
          pc_d = stale ? pc_n : pc_q + 32'd4;
        end
      end
      WAIT: begin
        drop_d = stale;
        if (imem_rsp_valid) begin
          if (stale) begin
            drop_d = 1'b0;
            state_d = go;
          end else begin
            state_d = HOLD;
            data_d = imem_rsp_data;
            ipc_d = req_pc_q;
            fault_d = imem_rsp_err ? 2'b01 : 2'b00;
          end
        end
      end
      default: begin
        // a misaligned redirect passes through IDLE so the killed buffer shows inst_valid low first
        if (redirect_valid) state_d = mis_n ? IDLE : go;
        else if (inst_ready) begin
          term_d = |fault_q;
          state_d = (|fault_q || halt) ? IDLE : REQ;
        end
      end
    endcase
    if (state_d == HOLD && mis_n) begin
      data_d = NOP_INSN;
      ipc_d = pc_n;
      fault_d = 2'b10;
      mis_d = 1'b0;
    end
    req_addr_d = (state_q == REQ) ? req_addr_q : pc_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_pc_q <= '0;
      data_q <= '0;
      ipc_q <= '0;
      fault_q <= '0;
      drop_q <= 1'b0;
      mis_q <= 1'b0;
      term_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_addr_q <= req_addr_d;
      req_pc_q <= req_pc_d;
      data_q <= data_d;
      ipc_q <= ipc_d;
      fault_q <= fault_d;
      drop_q <= drop_d;
      mis_q <= mis_d;
      term_q <= term_d;
    end
  end
  assign imem_req_valid = state_q == REQ;
  assign imem_req_addr = req_addr_q;
  assign inst_valid = state_q == HOLD;
  assign inst_data = data_q;
  assign inst_pc = ipc_q;
  assign inst_fault = fault_q;
  assign pc = pc_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: random imem/decode/redirect traffic checked against an instruction-stream model
module tb_fetch_controller;
  logic clk = 1'b0;
  logic reset, halt, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
  logic inst_valid, inst_ready;
  logic [31:0] redirect_target, imem_req_addr, imem_rsp_data, inst_data, inst_pc, pc;
  logic [1:0] inst_fault;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  fetch_controller dut (
    .clk(clk), .reset(reset), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .pc(pc)
  );
  logic [31:0] exp_pc, held_addr, held_data, held_ipc, pend_addr, exp_d;
  logic [1:0] held_fault, exp_f;
  logic term, req_held, inst_held, pend;
  int pend_cnt, halt_cnt, stall, n_del, n_fault;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h0BAD_0013;
  endfunction
  function automatic logic bad(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic check_reset();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_fault", 32'(inst_fault), 32'd0);
    check("rst_pc", pc, 32'd0);
  endtask
  task automatic model_reset();
    halt = 0; redirect_valid = 0; redirect_target = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0; inst_ready = 0;
    exp_pc = 0; term = 0; req_held = 0; inst_held = 0; pend = 0; pend_cnt = 0;
    halt_cnt = 0; stall = 0;
  endtask
  task automatic step();
    logic [31:0] t;
    if (term) begin
      check("term_no_req", 32'(imem_req_valid), 32'd0);
      check("term_no_inst", 32'(inst_valid), 32'd0);
    end
    if (req_held) begin
      check("req_held_valid", 32'(imem_req_valid), 32'd1);
      check("req_held_addr", imem_req_addr, held_addr);
    end else if (imem_req_valid) check("req_addr_is_pc", imem_req_addr, pc);
    if (inst_held) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_data", inst_data, held_data);
      check("hold_pc", inst_pc, held_ipc);
      check("hold_fault", 32'(held_fault), 32'(inst_fault));
    end
    check("stall", 32'(stall > 60), 32'd0);
    stall++;
    if (halt_cnt != 0) begin halt = 1; halt_cnt--; end
    else begin halt = 0; if ($urandom_range(0, 59) == 0) halt_cnt = int'($urandom_range(1, 8)); end
    inst_ready = $urandom_range(0, 3) != 0;
    redirect_valid = $urandom_range(0, 29) == 0;
    case ($urandom_range(0, 6))
      0: t = 32'h0000_0200;
      1: t = 32'h0000_0102;
      2: t = 32'hFFFF_FFF8;
      3: t = 32'hE000_0010;
      4: t = $urandom;
      default: t = $urandom_range(0, 4095) << 2;
    endcase
    redirect_target = redirect_valid ? t : $urandom;
    if (pend && pend_cnt == 0) begin
      imem_rsp_valid = 1; imem_rsp_data = mem(pend_addr); imem_rsp_err = bad(pend_addr); pend = 0;
    end else begin
      imem_rsp_valid = 0; imem_rsp_data = $urandom; imem_rsp_err = $urandom_range(0, 1) == 1;
      if (pend) pend_cnt--;
    end
    imem_req_ready = $urandom_range(0, 3) != 0;
    if (imem_req_valid && imem_req_ready) begin
      check("one_outstanding", 32'(pend), 32'd0);
      check("req_aligned", 32'(imem_req_addr[1:0]), 32'd0);
      pend = 1; pend_addr = imem_req_addr; pend_cnt = int'($urandom_range(0, 2));
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      exp_f = exp_pc[1:0] != 0 ? 2'b10 : (bad(exp_pc) ? 2'b01 : 2'b00);
      exp_d = exp_f == 2'b10 ? 32'h0000_0013 : mem(exp_pc);
      check("inst_pc", inst_pc, exp_pc);
      check("inst_fault", 32'(inst_fault), 32'(exp_f));
      check("inst_data", inst_data, exp_d);
      n_del++; stall = 0;
      if (exp_f != 0) begin term = 1; n_fault++; end
      else exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin exp_pc = redirect_target; term = 0; end
    if (halt || term || redirect_valid) stall = 0;
    req_held = imem_req_valid && !imem_req_ready;
    held_addr = imem_req_addr;
    inst_held = inst_valid && !inst_ready && !redirect_valid;
    held_data = inst_data; held_ipc = inst_pc; held_fault = inst_fault;
  endtask
  initial begin
    n_del = 0; n_fault = 0;
    model_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    reset = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        reset = 1;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        reset = 0;
      end
      step();
      @(negedge clk);
    end
    check("deliveries", 32'(n_del >= 100), 32'd1);
    check("faults_seen", 32'(n_fault > 0), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
